// File: rtl/tone_dir_qualifier.sv
// tone_dir_qualifier: qualifies one of NUM_CH tone-present flags and presents it
// as a direction code {stop, ch} until acknowledged or a hold window expires.
// Optional feature macro: TONE_DET_AMBIG_REJECT_EN (reject simultaneous tones).
// Handshake: dir_valid is high exactly while a direction is presented; the
// consumer raises dir_ack to accept it. dir_ack is only sampled while
// dir_valid is high, and a sampled ack ends the presentation on that edge.
module tone_dir_qualifier #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int QUAL_CYCLES = 12_500_000,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int DROP_CYCLES = 0,
    localparam int DIR_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] tone_in,
    input  logic              dir_ack,
    output logic [DIR_W:0]    td_dir,
    output logic              dir_valid,
    output logic              ambig_err
);

    localparam int MAX_QH  = (QUAL_CYCLES > HOLD_CYCLES) ? QUAL_CYCLES : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_QH > DROP_CYCLES) ? MAX_QH : DROP_CYCLES;

    // Parameter sanity checks at elaboration time.
    if (NUM_CH < 2) begin : g_chk_num_ch
        $error("tone_dir_qualifier: NUM_CH must be >= 2");
    end
    if (QUAL_CYCLES < 1) begin : g_chk_qual
        $error("tone_dir_qualifier: QUAL_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("tone_dir_qualifier: HOLD_CYCLES must be >= 1");
    end
    if ((CNT_W < 1) || ((MAX_CNT >> CNT_W) != 0)) begin : g_chk_cnt_w
        $error("tone_dir_qualifier: CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] QUAL_LIM  = CNT_W'(QUAL_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DROP_LIM  = CNT_W'(DROP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [DIR_W:0]   STOP_CODE = {1'b1, {DIR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_QUALIFY  = 3'd1,
        S_DETECTED = 3'd2,
        S_HOLD     = 3'd3,
        S_REARM    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIR_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]   qual_cnt_q, qual_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DIR_W:0]     td_dir_q, td_dir_d;
    logic               dir_valid_q, dir_valid_d;
    logic               ambig_err_q, ambig_err_d;

    logic [DIR_W-1:0]   low_idx;
    logic               cand_hit;
    logic               ambig_idle;
    logic               ambig_qual;

    // Lowest asserted channel index (lowest index wins on a tie).
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tone_in[i]) begin
                low_idx = DIR_W'(i);
            end
        end
    end

    assign cand_hit = tone_in[cand_q];

`ifdef TONE_DET_AMBIG_REJECT_EN
    logic [NUM_CH-1:0] other_bits;
    logic              multi_hot;

    // Ambiguity detection: more than one tone at capture, or a foreign tone while qualifying.
    always_comb begin
        multi_hot  = ((tone_in & (tone_in - NUM_CH'(1))) != '0);
        other_bits = tone_in & ~(NUM_CH'(1) << cand_q);
        ambig_idle = multi_hot;
        ambig_qual = (other_bits != '0);
    end
`else
    assign ambig_idle = 1'b0;
    assign ambig_qual = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        qual_cnt_d  = qual_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        td_dir_d    = td_dir_q;
        dir_valid_d = dir_valid_q;
        ambig_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                qual_cnt_d = '0;
                drop_cnt_d = '0;
                hold_cnt_d = '0;
                if (ambig_idle) begin
                    ambig_err_d = 1'b1;
                    state_d     = S_REARM;
                end else if (tone_in != '0) begin
                    // The capture sample is the first qualifying sample.
                    cand_d     = low_idx;
                    qual_cnt_d = CNT_ONE;
                    state_d    = S_QUALIFY;
                end
            end

            S_QUALIFY: begin
                if (ambig_qual) begin
                    ambig_err_d = 1'b1;
                    qual_cnt_d  = '0;
                    drop_cnt_d  = '0;
                    state_d     = S_REARM;
                end else if (qual_cnt_q == QUAL_LIM) begin
                    state_d = S_DETECTED;
                end else if (cand_hit) begin
                    qual_cnt_d = qual_cnt_q + CNT_ONE;
                    drop_cnt_d = '0;
                end else if (drop_cnt_q == DROP_LIM) begin
                    // Dropout run exceeded the tolerance: abandon this candidate.
                    qual_cnt_d = '0;
                    drop_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    drop_cnt_d = drop_cnt_q + CNT_ONE;
                end
            end

            S_DETECTED: begin
                td_dir_d    = {1'b0, cand_q};
                dir_valid_d = 1'b1;
                hold_cnt_d  = '0;
                qual_cnt_d  = '0;
                drop_cnt_d  = '0;
                state_d     = S_HOLD;
            end

            S_HOLD: begin
                // Expiry and ack on the same edge collapse into one exit.
                if ((hold_cnt_q == HOLD_LAST) || dir_ack) begin
                    td_dir_d    = STOP_CODE;
                    dir_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    state_d     = S_REARM;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end

            S_REARM: begin
                qual_cnt_d = '0;
                drop_cnt_d = '0;
                hold_cnt_d = '0;
                // Wait for every tone to disappear so a lingering tone cannot re-trigger.
                if (tone_in == '0) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                td_dir_d    = STOP_CODE;
                dir_valid_d = 1'b0;
                qual_cnt_d  = '0;
                drop_cnt_d  = '0;
                hold_cnt_d  = '0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State, counters and outputs; async reset returns everything to STOP/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            qual_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            td_dir_q    <= STOP_CODE;
            dir_valid_q <= 1'b0;
            ambig_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            qual_cnt_q  <= qual_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            td_dir_q    <= td_dir_d;
            dir_valid_q <= dir_valid_d;
            ambig_err_q <= ambig_err_d;
        end
    end

    assign td_dir    = td_dir_q;
    assign dir_valid = dir_valid_q;
    assign ambig_err = ambig_err_q;

endmodule

// File: tb/tb_tone_dir_qualifier.sv
// Testbench for tone_dir_qualifier: directed scenarios on a 4- and an 8-channel
// instance plus randomized traffic on the 4-channel instance checked against a
// behavioural model. Honours TONE_DET_AMBIG_REJECT_EN when defined.
`timescale 1ns/1ps
module tb_tone_dir_qualifier;

    localparam int QUAL = 8;
    localparam int HOLD = 20;
    localparam int DROP = 2;

`ifdef TONE_DET_AMBIG_REJECT_EN
    localparam bit AMB_EN = 1'b1;
`else
    localparam bit AMB_EN = 1'b0;
`endif

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] tone4 = '0;
    logic       ack4  = 1'b0;
    logic [2:0] dir4;
    logic       valid4;
    logic       amb4;

    logic [7:0] tone8 = '0;
    logic       ack8  = 1'b0;
    logic [3:0] dir8;
    logic       valid8;
    logic       amb8;

    int errors = 0;
    int checks = 0;

    tone_dir_qualifier #(
        .NUM_CH(4), .CNT_W(8), .QUAL_CYCLES(QUAL), .HOLD_CYCLES(HOLD), .DROP_CYCLES(DROP)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .tone_in(tone4), .dir_ack(ack4),
        .td_dir(dir4), .dir_valid(valid4), .ambig_err(amb4)
    );

    tone_dir_qualifier #(
        .NUM_CH(8), .CNT_W(8), .QUAL_CYCLES(QUAL), .HOLD_CYCLES(HOLD), .DROP_CYCLES(DROP)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .tone_in(tone8), .dir_ack(ack8),
        .td_dir(dir8), .dir_valid(valid8), .ambig_err(amb8)
    );

    // Behavioural model of the 4-channel instance
    localparam int M_WAIT     = 0;  // no candidate
    localparam int M_COUNT    = 1;  // counting high samples of a candidate
    localparam int M_ANNOUNCE = 2;  // qualified, direction appears on next edge
    localparam int M_SHOW     = 3;  // direction presented
    localparam int M_LOCK     = 4;  // waiting for silence

    int         m_mode  = M_WAIT;
    int         m_ch    = 0;
    int         m_hits  = 0;
    int         m_miss  = 0;
    int         m_shown = 0;
    logic [2:0] m_dir   = 3'b100;
    logic       m_valid = 1'b0;
    logic       m_amb   = 1'b0;

    function automatic int lowest(input logic [3:0] t);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) begin
            if (t[i]) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode  = M_WAIT;
        m_ch    = 0;
        m_hits  = 0;
        m_miss  = 0;
        m_shown = 0;
        m_dir   = 3'b100;
        m_valid = 1'b0;
        m_amb   = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] t, input logic a);
        logic [3:0] others;
        m_amb = 1'b0;
        case (m_mode)
            M_WAIT: begin
                if (t != 4'd0) begin
                    if (AMB_EN && ($countones(t) > 1)) begin
                        m_amb  = 1'b1;
                        m_mode = M_LOCK;
                    end else begin
                        m_ch   = lowest(t);
                        m_hits = 1;
                        m_miss = 0;
                        m_mode = M_COUNT;
                    end
                end
            end
            M_COUNT: begin
                others = t & ~(4'b0001 << m_ch);
                if (AMB_EN && (others != 4'd0)) begin
                    m_amb  = 1'b1;
                    m_mode = M_LOCK;
                end else if (m_hits == QUAL) begin
                    m_mode = M_ANNOUNCE;
                end else if (t[m_ch]) begin
                    m_hits = m_hits + 1;
                    m_miss = 0;
                end else if (m_miss == DROP) begin
                    m_mode = M_WAIT;
                end else begin
                    m_miss = m_miss + 1;
                end
            end
            M_ANNOUNCE: begin
                m_dir   = {1'b0, 2'(m_ch)};
                m_valid = 1'b1;
                m_shown = 0;
                m_mode  = M_SHOW;
            end
            M_SHOW: begin
                m_shown = m_shown + 1;
                if ((m_shown == HOLD) || a) begin
                    m_dir   = 3'b100;
                    m_valid = 1'b0;
                    m_mode  = M_LOCK;
                end
            end
            default: begin
                if (t == 4'd0) m_mode = M_WAIT;
            end
        endcase
    endtask

    // Driver tasks: called at a negedge, drive, take one posedge, return at next negedge.
    task automatic tick(input logic [3:0] t4, input logic a4, input logic [7:0] t8, input logic a8);
        tone4 = t4;
        ack4  = a4;
        tone8 = t8;
        ack8  = a8;
        @(posedge clk);
        model_step(t4, a4);
        @(negedge clk);
    endtask

    task automatic do_reset();
        tone4 = '0;
        ack4  = 1'b0;
        tone8 = '0;
        ack8  = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dir4 !== 3'b100) begin errors++; $display("FAIL reset_dir4 got %b want 100", dir4); end
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b want 0", valid4); end
        checks++; if (amb4 !== 1'b0) begin errors++; $display("FAIL reset_amb4 got %b want 0", amb4); end
        checks++; if (dir8 !== 4'b1000) begin errors++; $display("FAIL reset_dir8 got %b want 1000", dir8); end
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8 got %b want 0", valid8); end
    endtask

    task automatic test_steady();
        logic exp_v;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            tick(4'b0100, 1'b0, 8'h00, 1'b0);
            exp_v = (k >= 10) && (k <= 29);
            checks++; if (valid4 !== exp_v) begin errors++; $display("FAIL steady_valid edge=%0d got %b want %b", k, valid4, exp_v); end
            checks++; if (dir4 !== (exp_v ? 3'b010 : 3'b100)) begin errors++; $display("FAIL steady_dir edge=%0d got %b want %b", k, dir4, exp_v ? 3'b010 : 3'b100); end
        end
        for (int k = 1; k <= 10; k++) begin
            tick(4'b0100, 1'b0, 8'h00, 1'b0);
            checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL rearm_hold cycle=%0d got %b want 0", k, valid4); end
        end
        tick(4'b0000, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick(4'b0100, 1'b0, 8'h00, 1'b0);
        end
        checks++; if ({valid4, dir4} !== 4'b1010) begin errors++; $display("FAIL rearm_release got %b want 1010", {valid4, dir4}); end
    endtask

    task automatic test_dropout();
        do_reset();
        repeat (5) tick(4'b0010, 1'b0, 8'h00, 1'b0);
        repeat (3) tick(4'b0000, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick(4'b0010, 1'b0, 8'h00, 1'b0);
            checks++; if (valid4 !== (k == 10)) begin errors++; $display("FAIL drop_abort edge=%0d got %b want %b", k, valid4, k == 10); end
        end
        do_reset();
        repeat (5) tick(4'b0010, 1'b0, 8'h00, 1'b0);
        repeat (2) tick(4'b0000, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick(4'b0010, 1'b0, 8'h00, 1'b0);
            checks++; if (valid4 !== (k == 5)) begin errors++; $display("FAIL drop_tolerate edge=%0d got %b want %b", k, valid4, k == 5); end
        end
        checks++; if (dir4 !== 3'b001) begin errors++; $display("FAIL drop_tolerate_dir got %b want 001", dir4); end
    endtask

    task automatic test_ambig();
        logic exp_v;
        logic exp_a;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1001, 1'b0, 8'h00, 1'b0);
            exp_v = !AMB_EN && (k >= 10);
            exp_a = AMB_EN && (k == 1);
            checks++; if (valid4 !== exp_v) begin errors++; $display("FAIL ambig_valid edge=%0d got %b want %b", k, valid4, exp_v); end
            checks++; if (amb4 !== exp_a) begin errors++; $display("FAIL ambig_err edge=%0d got %b want %b", k, amb4, exp_a); end
            checks++; if (dir4 !== (exp_v ? 3'b000 : 3'b100)) begin errors++; $display("FAIL ambig_dir edge=%0d got %b want %b", k, dir4, exp_v ? 3'b000 : 3'b100); end
        end
    endtask

    task automatic test_ack();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(4'b0000, 1'b1, 8'h00, 1'b0);
            checks++; if ({valid4, dir4} !== 4'b0100) begin errors++; $display("FAIL ack_idle cycle=%0d got %b want 0100", k, {valid4, dir4}); end
        end
        for (int k = 1; k <= 14; k++) begin
            tick(4'b1000, (k <= 10), 8'h00, 1'b0);
            checks++; if (valid4 !== (k >= 10)) begin errors++; $display("FAIL ack_pre edge=%0d got %b want %b", k, valid4, k >= 10); end
        end
        checks++; if (dir4 !== 3'b011) begin errors++; $display("FAIL ack_dir got %b want 011", dir4); end
        tick(4'b1000, 1'b1, 8'h00, 1'b0);
        checks++; if ({valid4, dir4} !== 4'b0100) begin errors++; $display("FAIL ack_exit got %b want 0100", {valid4, dir4}); end
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1000, 1'b0, 8'h00, 1'b0);
            checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL ack_rearm cycle=%0d got %b want 0", k, valid4); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) tick(4'b0010, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({valid4, dir4} !== 4'b0100) begin errors++; $display("FAIL rst_qual got %b want 0100", {valid4, dir4}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick(4'b0010, 1'b0, 8'h00, 1'b0);
            checks++; if (valid4 !== (k >= 10)) begin errors++; $display("FAIL rst_requal edge=%0d got %b want %b", k, valid4, k >= 10); end
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({valid4, dir4} !== 4'b0100) begin errors++; $display("FAIL rst_hold got %b want 0100", {valid4, dir4}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wide();
        logic exp_v;
        do_reset();
        for (int k = 1; k <= 29; k++) begin
            tick(4'b0000, 1'b0, 8'h80, 1'b0);
            exp_v = (k >= 10);
            checks++; if (valid8 !== exp_v) begin errors++; $display("FAIL wide_valid edge=%0d got %b want %b", k, valid8, exp_v); end
            checks++; if (dir8 !== (exp_v ? 4'b0111 : 4'b1000)) begin errors++; $display("FAIL wide_dir edge=%0d got %b want %b", k, dir8, exp_v ? 4'b0111 : 4'b1000); end
        end
        tick(4'b0000, 1'b0, 8'h80, 1'b1);
        checks++; if ({valid8, dir8} !== 5'b01000) begin errors++; $display("FAIL wide_ack_expiry got %b want 01000", {valid8, dir8}); end
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0000, 1'b0, 8'h80, 1'b0);
            checks++; if ({valid8, dir8} !== 5'b01000) begin errors++; $display("FAIL wide_single_exit cycle=%0d got %b want 01000", k, {valid8, dir8}); end
        end
    endtask

    task automatic test_random();
        logic [3:0] pat;
        logic       a;
        int         sel;
        int         len;
        do_reset();
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 2) pat = 4'b0000;
            else if (sel <= 7) pat = 4'b0001 << $urandom_range(0, 3);
            else pat = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                a = ($urandom_range(0, 11) == 0);
                tick(pat, a, 8'h00, 1'b0);
                checks++; if (dir4 !== m_dir) begin errors++; $display("FAIL rand_dir seg=%0d got %b want %b", s, dir4, m_dir); end
                checks++; if (valid4 !== m_valid) begin errors++; $display("FAIL rand_valid seg=%0d got %b want %b", s, valid4, m_valid); end
                checks++; if (amb4 !== m_amb) begin errors++; $display("FAIL rand_amb seg=%0d got %b want %b", s, amb4, m_amb); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_dropout();
        test_ambig();
        test_ack();
        test_reset_mid();
        test_wide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
